tmip_input_loader: RTL and testbench
====================================

TMIP_INPUT_LOADER -- requirements
Module: tmip_input_loader

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1: image/template load phase strobe.
REQ-004 SHALL have port image, input, 16: signed pixel, one per in_valid cycle, raster order.
REQ-005 SHALL have port template, input, 16: signed template word, valid on the first 9 in_valid cycles only.
REQ-006 SHALL have port img_size, input, 5: image side (4, 8 or 16), valid on the first in_valid cycle only.
REQ-007 SHALL have port in_valid_2, input, 1: action phase strobe.
REQ-008 SHALL have port action, input, 2: action code, one per in_valid_2 cycle.
REQ-009 SHALL have port mem_we, output, 1: image buffer write enable.
REQ-010 SHALL have port mem_addr, output, 8: image buffer address.
REQ-011 SHALL have port mem_wdata, output, 16: image buffer write data.
REQ-012 SHALL have port tmpl, output, 144: 9 template words; word k at bits [16k+15:16k].
REQ-013 SHALL have port size_q, output, 5: latched img_size.
REQ-014 SHALL have port act_rd, input, 1: pop request for the action queue.
REQ-015 SHALL have port act_data, output, 2: head of the action queue.
REQ-016 SHALL have port act_empty, output, 1: action queue empty.
REQ-017 SHALL have port load_done, output, 1: one-cycle pulse when a full load is complete.
REQ-018 SHALL have port err, output, 1: sticky protocol error flag.

Function
REQ-019 SHALL implement states IDLE, IMG, GAP, ACT, DONE.
REQ-020 IDLE->IMG SHALL occur on a cycle with in_valid=1; that cycle latches size_q=img_size, writes template word 0 and pixel 0.
REQ-021 In IMG, each in_valid cycle n (n from 0) SHALL drive mem_we=1, mem_addr=n, mem_wdata=image, all registered, so the write appears exactly 1 cycle after the sample.
REQ-022 Template words SHALL be captured on in_valid cycles 0..8; template is ignored from cycle 9 onward.
REQ-023 IMG->GAP SHALL occur when in_valid falls; pixel count is held for checking.
REQ-024 GAP->ACT SHALL occur on the first in_valid_2=1 cycle; each in_valid_2 cycle pushes action into an 8-deep FIFO.
REQ-025 ACT->DONE SHALL occur when in_valid_2 falls; load_done SHALL pulse high for exactly 1 cycle in DONE, then return to IDLE.
REQ-026 load_done SHALL assert exactly 1 cycle after the last in_valid_2=1 cycle.
REQ-027 Action FIFO: act_data shows the head combinationally; act_rd with act_empty=0 pops; act_rd with act_empty=1 is ignored.
REQ-028 A simultaneous push and pop with a full FIFO SHALL pop the head and accept the push.
REQ-029 A push with the FIFO full and no pop SHALL be dropped.
REQ-030 A new IDLE->IMG transition SHALL clear the FIFO and tmpl before the new load.
REQ-031 mem_addr SHALL saturate at 255; writes beyond 256 pixels SHALL be suppressed (mem_we=0).

Reset
REQ-032 When rst=1 at a clock edge: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, tmpl=0, size_q=0, FIFO empty (act_empty=1, act_data=0), load_done=0, err=0.
REQ-033 Reset asserted mid-load SHALL abort the load without a load_done pulse; reset SHALL take priority over all inputs.

Configuration
REQ-034 With TMIP_LOADER_CHK_EN defined, err SHALL set and hold until reset on any of these conditions:
- img_size not in {4, 8, 16}
- pixel count != size_q*size_q at in_valid fall
- in_valid and in_valid_2 both high
- FIFO push dropped
- in_valid_2 high in IDLE
REQ-035 Without TMIP_LOADER_CHK_EN, err SHALL be constant 0 and no checking logic SHALL be present; all other behaviour is identical.

Verification
REQ-036 img_size=4, 16 pixels 1..16, template 1..9, actions {1,2,0} -> mem writes addr 0..15 data 1..16; tmpl word 8=9; size_q=4; load_done exactly 1 cycle after the last action; 3 pops return 1,2,0, then act_empty=1.
REQ-037 img_size=16, 256 pixels, 8 actions with no pops -> 256 writes; FIFO full; err=0 (CHK_EN).
REQ-038 9 actions with no pops -> 9th dropped; err=1 with CHK_EN, err=0 without; pops return the first 8 actions.
REQ-039 img_size=8 with only 60 pixels supplied -> err=1 at in_valid fall (CHK_EN); load_done still pulses after the action phase.
REQ-040 rst=1 at pixel 5 of a 4x4 load -> all outputs return to reset values the next cycle, no load_done; a subsequent clean 4x4 load completes correctly.
REQ-041 Full FIFO with simultaneous act_rd=1 and a push -> head popped, new action stored, count remains 8.

Source files
------------

// File: rtl/tmip_input_loader.sv
`default_nettype none
// ============================================================================
// Module      : tmip_input_loader
// Description : Loads image pixels into a buffer, captures a 3x3 template and
//               queues action codes. TMIP_LOADER_CHK_EN enables the sticky err.
// Revision    : 1.0 - initial release
// ============================================================================
module tmip_input_loader (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [15:0]  image,
    input  logic [15:0]  template,
    input  logic [4:0]   img_size,
    input  logic         in_valid_2,
    input  logic [1:0]   action,
    output logic         mem_we,
    output logic [7:0]   mem_addr,
    output logic [15:0]  mem_wdata,
    output logic [143:0] tmpl,
    output logic [4:0]   size_q,
    input  logic         act_rd,
    output logic [1:0]   act_data,
    output logic         act_empty,
    output logic         load_done,
    output logic         err
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_img  = 3'd1;
    localparam logic [2:0] c_st_gap  = 3'd2;
    localparam logic [2:0] c_st_act  = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;

    logic [2:0]   state_q, state_d;
    logic [8:0]   pix_cnt_q;
    logic         mem_we_q;
    logic [7:0]   mem_addr_q;
    logic [15:0]  mem_wdata_q;
    logic [143:0] tmpl_q, tmpl_d;
    logic [4:0]   img_size_q;
    logic [1:0]   fifo_q [8];
    logic [2:0]   rd_ptr_q, wr_ptr_q;
    logic [3:0]   count_q;
    logic         w_load_done;

    logic w_start, w_img_beat, w_img_end, w_push, w_pop, w_full, w_push_ok;

    assign w_start    = (state_q == c_st_idle) && in_valid;
    assign w_img_beat = (state_q == c_st_img) && in_valid;
    assign w_img_end  = (state_q == c_st_img) && !in_valid;
    assign w_push     = ((state_q == c_st_gap) || (state_q == c_st_act)) && in_valid_2;
    assign w_pop      = act_rd && (count_q != 4'd0);
    assign w_full     = (count_q == 4'd8);
    // A full queue still takes a push when the head leaves in the same cycle
    assign w_push_ok  = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) state_q <= c_st_idle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: if (in_valid)    state_d = c_st_img;
            c_st_img:  if (!in_valid)   state_d = c_st_gap;
            c_st_gap:  if (in_valid_2)  state_d = c_st_act;
            c_st_act:  if (!in_valid_2) state_d = c_st_done;
            c_st_done:                  state_d = c_st_idle;
            default:                    state_d = c_st_idle;
        endcase
    end

    // load_done rises on the edge that sees in_valid_2 low, one clock after the last push
    always_comb begin
        w_load_done = 1'b0;
        if (state_q == c_st_done) w_load_done = 1'b1;
    end

    always_comb begin
        tmpl_d = tmpl_q;
        if (w_start) begin
            tmpl_d = {128'd0, template};
        end else begin
            for (int k = 1; k < 9; k++) begin
                if (w_img_beat && (pix_cnt_q == 9'(k))) tmpl_d[16*k +: 16] = template;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt_q   <= 9'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 8'd0;
            mem_wdata_q <= 16'd0;
            tmpl_q      <= 144'd0;
            img_size_q  <= 5'd0;
        end else begin
            mem_we_q <= 1'b0;
            tmpl_q   <= tmpl_d;
            if (w_start) begin
                img_size_q  <= img_size;
                mem_we_q    <= 1'b1;
                mem_addr_q  <= 8'd0;
                mem_wdata_q <= image;
                pix_cnt_q   <= 9'd1;
            end else if (w_img_beat) begin
                if (pix_cnt_q < 9'd256) begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= pix_cnt_q[7:0];
                    mem_wdata_q <= image;
                end else begin
                    mem_addr_q  <= 8'hFF;
                end
                if (pix_cnt_q != 9'h1FF) pix_cnt_q <= pix_cnt_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            rd_ptr_q <= 3'd0;
            wr_ptr_q <= 3'd0;
            count_q  <= 4'd0;
        end else begin
            if (w_push_ok) begin
                fifo_q[wr_ptr_q] <= action;
                wr_ptr_q         <= wr_ptr_q + 3'd1;
            end
            if (w_pop) rd_ptr_q <= rd_ptr_q + 3'd1;
            case ({w_push_ok, w_pop})
                2'b10:   count_q <= count_q + 4'd1;
                2'b01:   count_q <= count_q - 4'd1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef TMIP_LOADER_CHK_EN
    logic       err_q;
    logic [9:0] w_size_sq;
    logic       w_err_set;

    assign w_size_sq = {5'd0, img_size_q} * {5'd0, img_size_q};
    assign w_err_set = (w_start && !((img_size == 5'd4) || (img_size == 5'd8) || (img_size == 5'd16)))
                     || (w_img_end && ({1'b0, pix_cnt_q} != w_size_sq))
                     || (in_valid && in_valid_2)
                     || (w_push && !w_push_ok)
                     || ((state_q == c_st_idle) && in_valid_2);

    always_ff @(posedge clk) begin
        if (rst)            err_q <= 1'b0;
        else if (w_err_set) err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign tmpl      = tmpl_q;
    assign size_q    = img_size_q;
    assign act_empty = (count_q == 4'd0);
    assign act_data  = (count_q == 4'd0) ? 2'b00 : fifo_q[rd_ptr_q];
    assign load_done = w_load_done;

endmodule
`default_nettype wire

// File: tb/tb_tmip_input_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_tmip_input_loader
// Description : Self-checking bench for tmip_input_loader (honours TMIP_LOADER_CHK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tmip_input_loader;
`ifdef TMIP_LOADER_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, in_valid, in_valid_2, act_rd;
    logic [15:0]  image, template;
    logic [4:0]   img_size;
    logic [1:0]   action;
    logic         mem_we, act_empty, load_done, err;
    logic [7:0]   mem_addr;
    logic [15:0]  mem_wdata;
    logic [143:0] tmpl;
    logic [4:0]   size_q;
    logic [1:0]   act_data;

    tmip_input_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .image(image), .template(template),
        .img_size(img_size), .in_valid_2(in_valid_2), .action(action), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .tmpl(tmpl), .size_q(size_q),
        .act_rd(act_rd), .act_data(act_data), .act_empty(act_empty),
        .load_done(load_done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0]  pix_a [0:299];
    logic [15:0]  tmp_a [0:8];
    logic [1:0]   act_a [0:15];

    int           q[$];
    logic         m_err;
    logic [143:0] m_tmpl;
    logic [4:0]   m_size;

    typedef struct {
        int          sz;
        int          npix;
        int          nact;
        logic [15:0] pop_mask;
        int          gap;
        logic        err_exp;
        int          remain_exp;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [143:0] got, input logic [143:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_valid_2 = 1'b0;
        act_rd     = 1'b0;
        image      = 16'($urandom);
        template   = 16'($urandom);
        img_size   = 5'($urandom);
        action     = 2'($urandom);
    endtask

    task automatic check_reset_outputs();
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_tmpl", tmpl, 0);
        chk("rst_size_q", size_q, 0);
        chk("rst_act_empty", act_empty, 1);
        chk("rst_act_data", act_data, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_err", err, 0);
    endtask

    task automatic model_reset();
        q.delete();
        m_err  = 1'b0;
        m_tmpl = '0;
        m_size = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        model_reset();
        check_reset_outputs();
        rst = 1'b0;
    endtask

    task automatic check_fifo();
        chk("act_empty", act_empty, q.size() == 0);
        chk("act_data", act_data, (q.size() > 0) ? q[0] : 0);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 300; i++) pix_a[i] = 16'($urandom);
        for (int i = 0; i < 9; i++)   tmp_a[i] = 16'($urandom);
        for (int i = 0; i < 16; i++)  act_a[i] = 2'($urandom);
    endtask

    task automatic run_load(input int sz, input int npix, input int nact,
                            input logic [15:0] pop_mask, input int gap, output int remain);
        for (int n = 0; n < npix; n++) begin
            in_valid   = 1'b1;
            in_valid_2 = 1'b0;
            act_rd     = 1'b0;
            image      = pix_a[n];
            template   = (n < 9) ? tmp_a[n] : 16'($urandom);
            img_size   = (n == 0) ? 5'(sz) : 5'($urandom);
            if (n == 0) begin
                q.delete();
                m_tmpl = '0;
                m_size = 5'(sz);
                if (!(sz == 4 || sz == 8 || sz == 16)) m_err = 1'b1;
            end
            if (n < 9) m_tmpl[16*n +: 16] = tmp_a[n];
            tick();
            chk("mem_we", mem_we, n < 256);
            chk("mem_addr", mem_addr, (n < 256) ? n : 255);
            if (n < 256) chk("mem_wdata", mem_wdata, pix_a[n]);
            if (n == 0) check_fifo();
        end
        for (int g = 0; g < gap; g++) begin
            idle_inputs();
            if (g == 0 && npix != sz * sz) m_err = 1'b1;
            tick();
            chk("gap_mem_we", mem_we, 0);
            chk("gap_load_done", load_done, 0);
        end
        chk("tmpl", tmpl, m_tmpl);
        chk("size_q", size_q, m_size);
        chk("err_after_img", err, CHK & m_err);
        for (int i = 0; i < nact; i++) begin
            bit pop;
            in_valid_2 = 1'b1;
            action     = act_a[i];
            act_rd     = pop_mask[i];
            check_fifo();
            pop = pop_mask[i] && (q.size() > 0);
            if (pop) void'(q.pop_front());
            if (q.size() < 8) q.push_back(int'(act_a[i]));
            else              m_err = 1'b1;
            tick();
            chk("act_load_done", load_done, 0);
            chk("act_err", err, CHK & m_err);
        end
        idle_inputs();
        tick();
        chk("load_done_pulse", load_done, 1);
        tick();
        chk("load_done_end", load_done, 0);
        chk("err_after_load", err, CHK & m_err);
        remain = q.size();
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            check_fifo();
            act_rd = 1'b1;
            tick();
            if (q.size() > 0) void'(q.pop_front());
        end
        act_rd = 1'b0;
        check_fifo();
    endtask

    initial begin
        int rem;
        tbl[0] = '{sz: 4,  npix: 16,  nact: 3, pop_mask: 16'h0000, gap: 2, err_exp: 1'b0, remain_exp: 3};
        tbl[1] = '{sz: 16, npix: 256, nact: 8, pop_mask: 16'h0000, gap: 1, err_exp: 1'b0, remain_exp: 8};
        tbl[2] = '{sz: 4,  npix: 16,  nact: 9, pop_mask: 16'h0000, gap: 2, err_exp: 1'b1, remain_exp: 8};
        tbl[3] = '{sz: 8,  npix: 60,  nact: 2, pop_mask: 16'h0000, gap: 2, err_exp: 1'b1, remain_exp: 2};
        tbl[4] = '{sz: 4,  npix: 16,  nact: 9, pop_mask: 16'h0100, gap: 1, err_exp: 1'b0, remain_exp: 8};
        tbl[5] = '{sz: 16, npix: 260, nact: 1, pop_mask: 16'h0000, gap: 3, err_exp: 1'b1, remain_exp: 1};
        tbl[6] = '{sz: 5,  npix: 25,  nact: 2, pop_mask: 16'h0000, gap: 1, err_exp: 1'b1, remain_exp: 2};
        tbl[7] = '{sz: 8,  npix: 64,  nact: 5, pop_mask: 16'h0016, gap: 2, err_exp: 1'b0, remain_exp: 2};

        rst = 1'b1;
        idle_inputs();
        model_reset();
        tick();
        tick();
        check_reset_outputs();
        rst = 1'b0;

        for (int t = 0; t < 8; t++) begin
            do_reset();
            fill_rand();
            if (t == 0) begin
                for (int i = 0; i < 16; i++) pix_a[i] = 16'(i + 1);
                for (int i = 0; i < 9; i++)  tmp_a[i] = 16'(i + 1);
                act_a[0] = 2'd1; act_a[1] = 2'd2; act_a[2] = 2'd0;
            end
            run_load(tbl[t].sz, tbl[t].npix, tbl[t].nact, tbl[t].pop_mask, tbl[t].gap, rem);
            if (t == 0) chk("tmpl_word8", tmpl[143:128], 16'd9);
            chk("tbl_err", err, CHK & tbl[t].err_exp);
            drain(tbl[t].remain_exp);
            chk("tbl_empty_after_drain", act_empty, 1);
        end

        // in_valid_2 while idle: flagged, never queued
        do_reset();
        in_valid_2 = 1'b1;
        action     = 2'd3;
        m_err      = 1'b1;
        tick();
        idle_inputs();
        chk("idle_v2_err", err, CHK & m_err);
        check_fifo();

        // reset in the middle of a 4x4 load
        do_reset();
        fill_rand();
        for (int n = 0; n < 6; n++) begin
            in_valid = 1'b1;
            image    = pix_a[n];
            template = tmp_a[n];
            img_size = (n == 0) ? 5'd4 : 5'($urandom);
            if (n == 5) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        model_reset();
        check_reset_outputs();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_no_done", load_done, 0);
        end
        run_load(4, 16, 3, 16'h0000, 1, rem);
        drain(rem);

        // randomized loads back to back, no reset, partial drains
        do_reset();
        for (int r = 0; r < 6; r++) begin
            int sz, npix;
            fill_rand();
            case ($urandom_range(0, 2))
                0:       sz = 4;
                1:       sz = 8;
                default: sz = 16;
            endcase
            npix = sz * sz - (($urandom_range(0, 4) == 0) ? 1 : 0);
            run_load(sz, npix, $urandom_range(1, 12), 16'($urandom), $urandom_range(1, 3), rem);
            drain($urandom_range(0, rem));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
